dendrite_arbiter: RTL

//  Arbitrates fires from NUM_SYN synapse ports plus one external incoming port onto a single dendrite unit.

---
 rtl/ucaspian_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/dendrite_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ucaspian_pkg.sv
// Shared uCaspian core constants and the dendrite fire payload.
// Contents:
//   UC_ADDR_W / UC_CHARGE_W : core-wide neuron address and charge widths
//   dend_fire_t             : one fire as held in the dendrite-facing register
//   ptr_width()             : index width for an N-entry pointer (minimum 1)
package ucaspian_pkg;

    localparam int unsigned UC_ADDR_W   = 8;
    localparam int unsigned UC_CHARGE_W = 8;

    // Charge carries one extra bit so both signed synapse and unsigned
    // incoming charges fit without loss.
    typedef struct packed {
        logic [UC_ADDR_W-1:0]          addr;
        logic signed [UC_CHARGE_W:0]   charge;
    } dend_fire_t;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i     : per-requester request
//   ptr_i     : index where the search starts (highest priority)
//   gnt_o     : one-hot grant, zero when no request
//   nxt_ptr_o : index just after the granted one (wraps), ptr_i when no grant
module rr_arbiter
    import ucaspian_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] nxt_ptr_o
);

    // Walk N positions starting at ptr_i; first requester found wins.
    always_comb begin
        logic              found;
        int unsigned       idx;
        logic [PTR_W-1:0]  sel;
        gnt_o     = '0;
        nxt_ptr_o = ptr_i;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                nxt_ptr_o  = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/dendrite_arbiter.sv
// Arbitrates NUM_SYN synapse ports plus one external incoming port onto a
// single dendrite unit through a registered output stage (1 fire/cycle).
// The incoming port has priority; synapse ports share round-robin.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   enable               : accept new fires (output stage always drains)
//   syn_addr/charge/vld  : packed per-port synapse fires, rdy one-hot out
//   in_addr/charge/vld   : external incoming fire, in_rdy out
//   dend_addr/charge/vld : registered fire to the dendrite, dend_rdy in
//   busy                 : anything pending at input or output
// Optional build macro DENDRITE_ARB_STARVE_EN: after IN_BURST consecutive
// incoming grants with synapses waiting, one synapse grant is forced.
module dendrite_arbiter
    import ucaspian_pkg::*;
#(
    parameter int unsigned NUM_SYN  = 4,
    parameter int unsigned ADDR_W   = UC_ADDR_W,
    parameter int unsigned CHARGE_W = UC_CHARGE_W,
    parameter int unsigned IN_BURST = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_SYN*ADDR_W-1:0]     syn_addr,
    input  logic [NUM_SYN*CHARGE_W-1:0]   syn_charge,
    input  logic [NUM_SYN-1:0]            syn_vld,
    output logic [NUM_SYN-1:0]            syn_rdy,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [CHARGE_W-1:0]           in_charge,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [ADDR_W-1:0]             dend_addr,
    output logic [CHARGE_W:0]             dend_charge,
    output logic                          dend_vld,
    input  logic                          dend_rdy,
    output logic                          busy
);

    localparam int unsigned PTR_W = ptr_width(NUM_SYN);

    // The output register uses the core-wide fire struct, so widths are pinned.
    if (NUM_SYN < 1 || IN_BURST < 1) begin : g_bad_cfg
        $error("dendrite_arbiter: NUM_SYN and IN_BURST must be >= 1");
    end
    if (ADDR_W != UC_ADDR_W || CHARGE_W != UC_CHARGE_W) begin : g_bad_width
        $error("dendrite_arbiter: ADDR_W/CHARGE_W must match ucaspian_pkg");
    end

    dend_fire_t         fire_q, fire_d, syn_fire_c;
    logic               vld_q, vld_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, rr_nxt_c;
    logic [NUM_SYN-1:0] rr_gnt_c;
    logic               accept_c, any_syn_c, block_in_c, in_gnt_c, syn_gnt_c;

    assign any_syn_c = |syn_vld;
    // Output stage empty or draining this cycle; nothing accepted in reset.
    assign accept_c  = enable & ~reset & (~vld_q | dend_rdy);

`ifdef DENDRITE_ARB_STARVE_EN
    localparam int unsigned BURST_W = $clog2(IN_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign block_in_c = any_syn_c & (burst_cnt_q == BURST_W'(IN_BURST));

    // Count incoming grants only while synapses are left waiting.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (in_gnt_c) begin
            burst_cnt_d = any_syn_c ? burst_cnt_q + BURST_W'(1) : '0;
        end else if (syn_gnt_c) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign block_in_c = 1'b0;
`endif

    rr_arbiter #(.N(NUM_SYN)) u_rr (
        .req_i     (syn_vld),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (rr_gnt_c),
        .nxt_ptr_o (rr_nxt_c)
    );

    assign in_gnt_c  = accept_c & in_vld & ~block_in_c;
    assign syn_rdy   = (accept_c & ~in_gnt_c) ? rr_gnt_c : '0;
    assign syn_gnt_c = |syn_rdy;
    assign in_rdy    = in_gnt_c;
    assign busy      = vld_q | in_vld | any_syn_c;

    // One-hot select of the granted synapse fire, charge sign-extended.
    always_comb begin
        syn_fire_c = '0;
        for (int unsigned i = 0; i < NUM_SYN; i++) begin
            if (rr_gnt_c[i]) begin
                syn_fire_c.addr   = syn_addr[i*ADDR_W +: ADDR_W];
                syn_fire_c.charge = {syn_charge[i*CHARGE_W + CHARGE_W - 1],
                                     syn_charge[i*CHARGE_W +: CHARGE_W]};
            end
        end
    end

    // Output register next state: load on grant, clear valid on drain.
    always_comb begin
        fire_d   = fire_q;
        vld_d    = vld_q;
        rr_ptr_d = rr_ptr_q;
        if (in_gnt_c) begin
            fire_d.addr   = in_addr;
            fire_d.charge = {1'b0, in_charge};
            vld_d         = 1'b1;
        end else if (syn_gnt_c) begin
            fire_d   = syn_fire_c;
            vld_d    = 1'b1;
            rr_ptr_d = rr_nxt_c;
        end else if (dend_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q   <= '0;
            vld_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            fire_q   <= fire_d;
            vld_q    <= vld_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign dend_addr   = fire_q.addr;
    assign dend_charge = fire_q.charge;
    assign dend_vld    = vld_q;

endmodule
